// File: rtl/inv_lift53_if.sv
// Handshake bundle for the inverse 5/3 lifting stage: coefficient pairs in,
// reconstructed sample pairs out.
interface inv_lift53_if #(
    parameter int W = 24
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_low;
    logic signed [W-1:0] in_high;
    logic                in_first;
    logic                in_last;
    logic                out_valid;
    logic signed [W-1:0] out_even;
    logic signed [W-1:0] out_odd;
    logic                out_first;
    logic                out_last;

    modport master (
        output in_valid, in_low, in_high, in_first, in_last,
        input  in_ready, out_valid, out_even, out_odd, out_first, out_last
    );

    modport slave (
        input  in_valid, in_low, in_high, in_first, in_last,
        output in_ready, out_valid, out_even, out_odd, out_first, out_last
    );
endinterface

// File: rtl/inv_lift53.sv
// Streaming 1-D inverse 5/3 reversible lifting. Consumes (s[k], d[k]) pairs and
// emits (x[2k], x[2k+1]) one cycle after pair k+1 arrives; the last pair of a
// row is emitted from a one-cycle FLUSH state using symmetric extension.
//
// state | meaning
// IDLE  | waiting for in_first; other beats are dropped
// RUN   | row in progress, one pair held in e_prev/d_prev
// FLUSH | emitting the final pair of the row, input stalled
module inv_lift53 #(
    parameter int W = 24
) (
    input logic         clk,
    input logic         rst,
    inv_lift53_if.slave bus
);
    localparam int WX = W + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic signed [W-1:0] e_prev_q, e_prev_d;
    logic signed [W-1:0] d_prev_q, d_prev_d;
    logic                first_pend_q, first_pend_d;
    logic                out_valid_q, out_valid_d;
    logic signed [W-1:0] out_even_q, out_even_d;
    logic signed [W-1:0] out_odd_q, out_odd_d;
    logic                out_first_q, out_first_d;
    logic                out_last_q, out_last_d;

    logic                xfer;
    logic                start;
    logic signed [W-1:0] d_ref;
    logic signed [WX-1:0] low_x, high_x, dref_x, dsum, dq;
    logic signed [WX-1:0] ep_x, en_x, dp_x, esum, eh;
    logic signed [W-1:0] e_new;
    logic signed [W-1:0] odd_run;
    logic signed [W-1:0] odd_flush;

    assign bus.in_ready  = (state_q != FLUSH);
    assign bus.out_valid = out_valid_q;
    assign bus.out_even  = out_even_q;
    assign bus.out_odd   = out_odd_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;

    assign xfer  = bus.in_valid & bus.in_ready;
    // in_first restarts a row from IDLE or RUN alike (in_ready excludes FLUSH)
    assign start = xfer & bus.in_first;

    // The first pair of a row mirrors itself: d[-1] = d[0]
    assign d_ref  = (state_q == RUN && !bus.in_first) ? d_prev_q : bus.in_high;

    // Sums are formed sign-extended at W+2 bits; shifts kept as standalone
    // signed assignments so they stay arithmetic.
    assign low_x  = {{2{bus.in_low[W-1]}}, bus.in_low};
    assign high_x = {{2{bus.in_high[W-1]}}, bus.in_high};
    assign dref_x = {{2{d_ref[W-1]}}, d_ref};
    assign dsum   = dref_x + high_x + WX'(2);
    assign dq     = dsum >>> 2;
    assign e_new  = W'(low_x - dq);

    assign ep_x      = {{2{e_prev_q[W-1]}}, e_prev_q};
    assign en_x      = {{2{e_new[W-1]}}, e_new};
    assign dp_x      = {{2{d_prev_q[W-1]}}, d_prev_q};
    assign esum      = ep_x + en_x;
    assign eh        = esum >>> 1;
    assign odd_run   = W'(dp_x + eh);
    assign odd_flush = W'(dp_x + ep_x);

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            e_prev_q     <= '0;
            d_prev_q     <= '0;
            first_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_even_q   <= '0;
            out_odd_q    <= '0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            e_prev_q     <= e_prev_d;
            d_prev_q     <= d_prev_d;
            first_pend_q <= first_pend_d;
            out_valid_q  <= out_valid_d;
            out_even_q   <= out_even_d;
            out_odd_q    <= out_odd_d;
            out_first_q  <= out_first_d;
            out_last_q   <= out_last_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = bus.in_last ? FLUSH : RUN;
            end
            RUN: begin
                if (start)                    state_d = bus.in_last ? FLUSH : RUN;
                else if (xfer && bus.in_last) state_d = FLUSH;
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pending-pair update and registered output pair
    always_comb begin
        e_prev_d     = e_prev_q;
        d_prev_d     = d_prev_q;
        first_pend_d = first_pend_q;
        out_valid_d  = 1'b0;
        out_even_d   = out_even_q;
        out_odd_d    = out_odd_q;
        out_first_d  = out_first_q;
        out_last_d   = out_last_q;
        if (start) begin
            // A mid-row in_first discards the held pair without emitting it
            e_prev_d     = e_new;
            d_prev_d     = bus.in_high;
            first_pend_d = 1'b1;
        end else if (state_q == RUN && xfer) begin
            out_valid_d  = 1'b1;
            out_even_d   = e_prev_q;
            out_odd_d    = odd_run;
            out_first_d  = first_pend_q;
            out_last_d   = 1'b0;
            e_prev_d     = e_new;
            d_prev_d     = bus.in_high;
            first_pend_d = 1'b0;
        end else if (state_q == FLUSH) begin
            // e[K] = e[K-1], so the odd sample collapses to d + e
            out_valid_d  = 1'b1;
            out_even_d   = e_prev_q;
            out_odd_d    = odd_flush;
            out_first_d  = first_pend_q;
            out_last_d   = 1'b1;
            first_pend_d = 1'b0;
        end
    end
endmodule

// File: tb/tb_inv_lift53.sv
module tb_inv_lift53;
    localparam int W = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inv_lift53_if #(.W(W)) bus ();

    inv_lift53 #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        longint ev;
        longint od;
        bit     f;
        bit     l;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     checks = 0;
    int     errors = 0;
    int     nvalid = 0;
    int     n0;
    longint rs[16], rd[16], xe[16], xo[16], xs[32];

    function automatic longint wrapw(input longint v);
        logic signed [W-1:0] t;
        t = v[W-1:0];
        return longint'(t);
    endfunction

    task automatic check(input string name, input longint act, input longint exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
        end
    endtask

    // Inverse lifting straight from the definition, on whole-row arrays
    task automatic model_inverse(input int K);
        longint dm1, en;
        for (int k = 0; k < K; k++) begin
            dm1   = (k == 0) ? rd[0] : rd[k-1];
            xe[k] = wrapw(rs[k] - ((dm1 + rd[k] + 2) >>> 2));
        end
        for (int k = 0; k < K; k++) begin
            en    = (k == K - 1) ? xe[k] : xe[k+1];
            xo[k] = wrapw(rd[k] + ((xe[k] + en) >>> 1));
        end
    endtask

    // Forward 5/3 lift of random samples xs -> (rs, rd)
    task automatic forward(input int K);
        longint xn, dm1;
        for (int k = 0; k < K; k++) begin
            xn    = (k == K - 1) ? xs[2*k] : xs[2*k+2];
            rd[k] = xs[2*k+1] - ((xs[2*k] + xn) >>> 1);
        end
        for (int k = 0; k < K; k++) begin
            dm1   = (k == 0) ? rd[0] : rd[k-1];
            rs[k] = xs[2*k] + ((dm1 + rd[k] + 2) >>> 2);
        end
    endtask

    task automatic rand_samples(input int K);
        for (int i = 0; i < 2*K; i++)
            xs[i] = longint'($urandom_range(0, (1 << 21) - 1)) - longint'(1 << 20);
        forward(K);
    endtask

    task automatic push(input longint ev, input longint od, input bit f, input bit l);
        exp_t e;
        e.ev = ev; e.od = od; e.f = f; e.l = l;
        sb.push_back(e);
    endtask

    task automatic push_samples(input int k0, input int k1, input int K);
        for (int k = k0; k <= k1; k++) push(xs[2*k], xs[2*k+1], k == 0, k == K - 1);
    endtask

    task automatic push_model(input int K);
        for (int k = 0; k < K; k++) push(xe[k], xo[k], k == 0, k == K - 1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge
    task automatic send(input longint s, input longint d, input bit f, input bit l);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_low   = W'(s);
        bus.in_high  = W'(d);
        bus.in_first = f;
        bus.in_last  = l;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 expected=1");
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_row(input int K, input int gapmax);
        for (int k = 0; k < K; k++) begin
            send(rs[k], rd[k], k == 0, k == K - 1);
            if (gapmax > 0 && k != K - 1) idle(int'($urandom_range(0, gapmax)));
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            nvalid++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid actual_even=%0d actual_odd=%0d expected=none",
                         bus.out_even, bus.out_odd);
            end else begin
                mon_e = sb.pop_front();
                check("out_even", longint'(bus.out_even), mon_e.ev);
                check("out_odd", longint'(bus.out_odd), mon_e.od);
                check("out_first", longint'(bus.out_first), longint'(mon_e.f));
                check("out_last", longint'(bus.out_last), longint'(mon_e.l));
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_low   = '0;
        bus.in_high  = '0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_even", longint'(bus.out_even), 0);
        check("rst_out_odd", longint'(bus.out_odd), 0);
        check("rst_out_first", longint'(bus.out_first), 0);
        check("rst_out_last", longint'(bus.out_last), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", longint'(bus.in_ready), 1);

        // Known two-pair row
        push(10, 20, 1'b1, 1'b0);
        push(30, 40, 1'b0, 1'b1);
        send(10, 0, 1'b1, 1'b0);
        send(33, 10, 1'b0, 1'b1);
        check("t1_valid_t+1", longint'(bus.out_valid), 1);
        check("t1_ready_t+1", longint'(bus.in_ready), 0);
        @(negedge clk);
        check("t1_valid_t+2", longint'(bus.out_valid), 1);
        check("t1_ready_t+2", longint'(bus.in_ready), 1);

        // Single-pair row with negative floor
        push(-4, -7, 1'b1, 1'b1);
        send(-5, -3, 1'b1, 1'b1);
        check("t2_valid_t+1", longint'(bus.out_valid), 0);
        check("t2_ready_t+1", longint'(bus.in_ready), 0);
        @(negedge clk);
        check("t2_valid_t+2", longint'(bus.out_valid), 1);
        idle(2);

        // Random 8-pair row with gaps, round trip through forward lift
        rand_samples(8);
        push_samples(0, 7, 8);
        n0 = nvalid;
        send_row(8, 2);
        idle(4);
        check("t3_pulse_count", longint'(nvalid - n0), 8);

        // Reset after three pairs of a six-pair row
        rand_samples(6);
        push_samples(0, 1, 6);
        for (int k = 0; k < 3; k++) send(rs[k], rd[k], k == 0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_rst_even", longint'(bus.out_even), 0);
        check("t4_rst_odd", longint'(bus.out_odd), 0);
        check("t4_rst_valid", longint'(bus.out_valid), 0);
        rst = 1'b0;
        n0 = nvalid;
        idle(5);
        check("t4_no_pulses", longint'(nvalid - n0), 0);
        check("t4_sb_empty", longint'(sb.size()), 0);
        rand_samples(5);
        push_samples(0, 4, 5);
        send_row(5, 1);
        idle(4);

        // Orphan beats, then a row aborted by a new in_first
        n0 = nvalid;
        for (int k = 0; k < 3; k++) send(100 + k, 7 * k, 1'b0, k == 2);
        send(123, 45, 1'b1, 1'b0);
        rand_samples(4);
        push_samples(0, 3, 4);
        send_row(4, 0);
        idle(4);
        check("t5_pulse_count", longint'(nvalid - n0), 4);

        // Extreme values
        push(-4194305, 4194303, 1'b1, 1'b1);
        send(longint'(24'h7FFFFF), -longint'(1 << 23), 1'b1, 1'b1);
        idle(2);
        for (int k = 0; k < 3; k++) begin
            rs[k] = 8388607;
            rd[k] = -8388608;
        end
        model_inverse(3);
        push_model(3);
        send_row(3, 0);
        idle(2);
        for (int k = 0; k < 6; k++) begin
            rs[k] = wrapw(longint'($urandom));
            rd[k] = wrapw(longint'($urandom));
        end
        model_inverse(6);
        push_model(6);
        send_row(6, 1);
        idle(5);
        check("final_sb_empty", longint'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/inv_lift53.md
# inv_lift53

Streaming 1-D inverse 5/3 (reversible, JPEG 2000) lifting stage: it undoes the forward lifting step.
- Input: one row as interleaved low/high coefficient pairs (s[k], d[k]).
- Output: reconstructed sample pairs (x[2k], x[2k+1]).
- Placement: sits after coefficient storage in the decode path, one instance per row/column pass, on the same 24-bit signed datapath as the forward lifting step.

## Interface
Parameters:
- W, 24, coefficient/sample width (signed two's complement)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input pair present
- in_ready  out  1  block accepts pair this cycle; transfer = in_valid & in_ready
- in_low  in  W  s[k], signed
- in_high  in  W  d[k], signed
- in_first  in  1  pair is k=0 of a row
- in_last  in  1  pair is k=K-1 of a row; may coincide with in_first
- out_valid  out  1  output pair valid, single-cycle pulse per pair; no backpressure
- out_even  out  W  x[2k], signed
- out_odd  out  W  x[2k+1], signed
- out_first  out  1  pair is k=0 of the row
- out_last  out  1  pair is k=K-1 of the row

## Operation
- Inverse lifting uses floor division (arithmetic shift right) with symmetric extension:
  - e[k] = s[k] - ((d[k-1] + d[k] + 2) >>> 2), where d[-1] = d[0]
  - o[k] = d[k] + ((e[k] + e[k+1]) >>> 1), where e[K] = e[K-1], so o[K-1] = d[K-1] + e[K-1]
- Width rules:
  - Intermediate sums are W+2 bits, sign-extended.
  - Results are truncated to W bits (wrap); no saturation.
- Internal registers: e_prev, d_prev, first_pend (output pair carries out_first).
- States: IDLE, RUN, FLUSH.
  - IDLE: in_ready=1. Transfer with in_first: compute e0, load e_prev=e0, d_prev=d0, first_pend=1, no output. Go to FLUSH if in_last, else RUN. Transfers without in_first are dropped.
  - RUN: in_ready=1. Transfer of pair k (no in_first):
    - compute e_k from s_k, d_prev, d_k;
    - register output (e_prev, d_prev + ((e_prev + e_k) >>> 1)), out_first=first_pend, out_last=0;
    - then e_prev=e_k, d_prev=d_k, first_pend=0;
    - go to FLUSH if in_last.
  - RUN, transfer with in_first (protocol error): discard pending pair, no output, restart as IDLE+in_first.
  - FLUSH: in_ready=0. Register output (e_prev, d_prev + e_prev), out_first=first_pend, out_last=1. Go to IDLE.
- Reset: state=IDLE, in_ready=1 after reset release, out_valid=0, out_even=0, out_odd=0, out_first=0, out_last=0, internal registers 0. Reset mid-row discards the row with no partial outputs.

## Timing
- Output pair k-1 has out_valid=1 in the cycle after pair k transfers (1-cycle registered latency).
- Last pair: out_valid for pair K-2 at t+1 and for pair K-1 at t+2, where t is the in_last transfer cycle; in_ready=0 during t+1 only.
- Next row's in_first is accepted at t+2 at the earliest. Throughput is one pair per cycle within a row, plus one bubble per row.
- Single-pair row (in_first & in_last on the same beat): one output at t+2 with out_first=out_last=1.
- Idle gaps (in_valid=0) within RUN are allowed; they hold all state and produce no output.
- out_valid is never asserted except in the cycle after a RUN transfer or a FLUSH state.

## Test plan
- Row s=[10,33], d=[0,10] with no gaps -> outputs (10,20) [out_first], then (30,40) [out_last] on consecutive cycles; in_ready low the cycle after the last beat.
- Single pair s=-5, d=-3, first&last -> one output (-4,-7), out_first=out_last=1, 2 cycles after the transfer (checks negative floor).
- 8-pair random row with random in_valid gaps, W=24 -> bit-exact against a forward-lift reference model round-trip; pairs output in order, exactly 8 out_valid pulses.
- rst asserted after 3 pairs of a 6-pair row -> no further out_valid; all outputs 0; the next full row decodes correctly.
- Pairs sent before any in_first, then in_first mid-row -> dropped pairs and the aborted row produce no output; the new row decodes correctly.
- Extreme values s=0x7FFFFF, d=0x800000 -> outputs equal the W-bit truncation of the W+2-bit computation.
